// File: rtl/renode_axi_burst_manager_if.sv
// Bundle of every handshake/bus signal around the burst manager: the command,
// write-beat, read-beat and completion streams on the user side, and the five
// AXI4 manager channels on the bus side.
//
// Handshake rule for every channel in this bundle: a transfer happens on the
// rising aclk edge where valid and ready are both 1; once valid is raised
// its payload is held stable and valid is not dropped until that edge; ready
// may rise or fall at any time and never waits on valid.
//
// Modports:
//   master - the burst manager itself (drives AW/W/AR, bready/rready,
//            cmd_ready, wr_ready, rd_*, rsp_*)
//   slave  - the environment (command source, beat producer/consumer and
//            the AXI subordinate)
interface renode_axi_burst_manager_if #(
   parameter int AddressWidth       = 32,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8
);
   localparam int StrobeWidth = DataWidth / 8;

   // command stream
   logic                          cmd_valid;
   logic                          cmd_ready;
   logic                          cmd_write;
   logic [AddressWidth-1:0]       cmd_addr;
   logic [2:0]                    cmd_size;
   logic [7:0]                    cmd_len;
   logic [TransactionIdWidth-1:0] cmd_id;
   // write-beat stream
   logic                          wr_valid;
   logic                          wr_ready;
   logic [DataWidth-1:0]          wr_data;
   // read-beat stream
   logic                          rd_valid;
   logic                          rd_ready;
   logic [DataWidth-1:0]          rd_data;
   logic                          rd_last;
   // completion
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic                          rsp_error;
   // AXI write address
   logic [TransactionIdWidth-1:0] awid;
   logic [AddressWidth-1:0]       awaddr;
   logic [7:0]                    awlen;
   logic [2:0]                    awsize;
   logic [1:0]                    awburst;
   logic                          awvalid;
   logic                          awready;
   // AXI write data
   logic [DataWidth-1:0]          wdata;
   logic [StrobeWidth-1:0]        wstrb;
   logic                          wlast;
   logic                          wvalid;
   logic                          wready;
   // AXI write response
   logic [TransactionIdWidth-1:0] bid;
   logic [1:0]                    bresp;
   logic                          bvalid;
   logic                          bready;
   // AXI read address
   logic [TransactionIdWidth-1:0] arid;
   logic [AddressWidth-1:0]       araddr;
   logic [7:0]                    arlen;
   logic [2:0]                    arsize;
   logic [1:0]                    arburst;
   logic                          arvalid;
   logic                          arready;
   // AXI read data
   logic [TransactionIdWidth-1:0] rid;
   logic [DataWidth-1:0]          rdata;
   logic [1:0]                    rresp;
   logic                          rlast;
   logic                          rvalid;
   logic                          rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, cmd_id,
      output cmd_ready,
      input  wr_valid, wr_data,
      output wr_ready,
      output rd_valid, rd_data, rd_last,
      input  rd_ready,
      output rsp_valid, rsp_error,
      input  rsp_ready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, cmd_id,
      input  cmd_ready,
      output wr_valid, wr_data,
      input  wr_ready,
      input  rd_valid, rd_data, rd_last,
      output rd_ready,
      input  rsp_valid, rsp_error,
      output rsp_ready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/renode_axi_burst_manager.sv
// Single-outstanding AXI4 burst manager. A command (direction, address, size,
// len, id) is latched, checked for legality (beat width, alignment, 4 KiB
// crossing) and turned into one INCR burst. Write beats and read beats are
// passed straight between the user streams and the W/R channels; one
// completion with a sticky error flag is returned per command.
//
// Ports:
//   aclk      - clock, rising edge
//   areset_n  - asynchronous active-low reset; aborts any burst in flight
//   bus       - master view of renode_axi_burst_manager_if (command, beat
//               streams, completion and the AXI AW/W/B/AR/R channels)
//   dbg_state - current FSM state encoding (IDLE=0 .. RSP=7)
module renode_axi_burst_manager #(
   parameter int AddressWidth       = 32,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8
) (
   input  logic                          aclk,
   input  logic                          areset_n,
   renode_axi_burst_manager_if.master    bus,
   output logic [2:0]                    dbg_state
);
   localparam int          StrobeWidth = DataWidth / 8;
   localparam int          LaneBits    = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;
   localparam logic [8:0]  StrbW9      = 9'(StrobeWidth);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_AR, S_R, S_AW, S_W, S_B, S_RSP
   } state_t;

   state_t                        state_q, state_d;
   logic                          write_q;
   logic [AddressWidth-1:0]       addr_q;
   logic [AddressWidth-1:0]       beat_addr_q;
   logic [2:0]                    size_q;
   logic [7:0]                    len_q;
   logic [TransactionIdWidth-1:0] id_q;
   logic [7:0]                    beat_cnt_q;
   logic                          err_q;

   logic [7:0]  size_bytes;
   logic [16:0] span_end;
   logic        illegal;
   logic        last_beat;
   logic        r_hs;
   logic        w_hs;
   logic        r_bad;
   logic [StrobeWidth-1:0] wstrb_c;
   int          lane_off;
   int          size_int;

   assign size_bytes = 8'd1 << size_q;
   assign last_beat  = (beat_cnt_q == len_q);
   assign r_hs       = (state_q == S_R) && bus.rvalid && bus.rd_ready;
   assign w_hs       = (state_q == S_W) && bus.wr_valid && bus.wready;
   assign r_bad      = (bus.rresp != 2'b00) || (bus.rid != id_q) || (bus.rlast != last_beat);

   // One past the last byte, measured from the start of the 4 KiB page; the
   // burst may end exactly on the page boundary but not beyond it.
   assign span_end = {5'd0, addr_q[11:0]} + (17'({1'b0, len_q} + 9'd1) << size_q);
   assign illegal  = ({1'b0, size_bytes} > StrbW9)
                   || (|(addr_q[7:0] & (size_bytes - 8'd1)))
                   || (span_end > 17'h01000);

   // Byte lanes of the current beat: size_bytes ones starting at the lane the
   // beat address falls on.
   always_comb begin
      lane_off = (StrobeWidth > 1) ? int'(beat_addr_q[LaneBits-1:0]) : 0;
      size_int = int'(size_bytes);
      wstrb_c  = '0;
      for (int i = 0; i < StrobeWidth; i++) begin
         if ((i >= lane_off) && (i < lane_off + size_int)) wstrb_c[i] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.cmd_valid) state_d = S_CHECK;
         S_CHECK: state_d = illegal ? S_RSP : (write_q ? S_AW : S_AR);
         S_AR:    if (bus.arready) state_d = S_R;
         S_R:     if (r_hs && bus.rlast) state_d = S_RSP;
         S_AW:    if (bus.awready) state_d = S_W;
         S_W:     if (w_hs && last_beat) state_d = S_B;
         S_B:     if (bus.bvalid) state_d = S_RSP;
         S_RSP:   if (bus.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: AXI valids/readies decode only the state register; the beat
   // streams are gated pass-throughs in R and W.
   always_comb begin
      bus.cmd_ready = areset_n && (state_q == S_IDLE);
      bus.arvalid   = (state_q == S_AR);
      bus.awvalid   = (state_q == S_AW);
      bus.bready    = (state_q == S_B);
      bus.rsp_valid = (state_q == S_RSP);
      bus.rsp_error = (state_q == S_RSP) && err_q;
      bus.rready    = (state_q == S_R) && bus.rd_ready;
      bus.rd_valid  = (state_q == S_R) && bus.rvalid;
      bus.rd_last   = (state_q == S_R) && bus.rlast;
      bus.wvalid    = (state_q == S_W) && bus.wr_valid;
      bus.wr_ready  = (state_q == S_W) && bus.wready;
      bus.wlast     = (state_q == S_W) && last_beat;
   end

   assign bus.rd_data = bus.rdata;
   assign bus.wdata   = bus.wr_data;
   assign bus.wstrb   = wstrb_c;
   assign bus.awid    = id_q;
   assign bus.awaddr  = addr_q;
   assign bus.awlen   = len_q;
   assign bus.awsize  = size_q;
   assign bus.awburst = 2'b01;
   assign bus.arid    = id_q;
   assign bus.araddr  = addr_q;
   assign bus.arlen   = len_q;
   assign bus.arsize  = size_q;
   assign bus.arburst = 2'b01;
   assign dbg_state   = state_q;

   // Latched command, beat tracking and sticky error
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         write_q     <= 1'b0;
         addr_q      <= '0;
         beat_addr_q <= '0;
         size_q      <= '0;
         len_q       <= '0;
         id_q        <= '0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
               write_q <= bus.cmd_write;
               addr_q  <= bus.cmd_addr;
               size_q  <= bus.cmd_size;
               len_q   <= bus.cmd_len;
               id_q    <= bus.cmd_id;
               err_q   <= 1'b0;
            end
            S_CHECK: begin
               if (illegal) err_q <= 1'b1;
               beat_addr_q <= addr_q;
            end
            S_AR: if (bus.arready) beat_cnt_q <= '0;
            S_AW: if (bus.awready) beat_cnt_q <= '0;
            S_R: if (r_hs) begin
               if (r_bad) err_q <= 1'b1;
               // saturate so a len=255 burst cannot wrap back to 0
               if (beat_cnt_q != 8'hFF) beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            S_W: if (w_hs) begin
               beat_addr_q <= beat_addr_q + AddressWidth'(size_bytes);
               if (beat_cnt_q != 8'hFF) beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            S_B: if (bus.bvalid) begin
               if ((bus.bresp != 2'b00) || (bus.bid != id_q)) err_q <= 1'b1;
            end
            S_RSP: if (bus.rsp_ready) err_q <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_renode_axi_burst_manager.sv
// Bench for renode_axi_burst_manager: directed commands with hand-computed
// expected AR/AW payloads, write strobes, read beats and completions pushed
// into queues; a negedge monitor pops and compares on every handshake.
module tb_renode_axi_burst_manager;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int IW  = 8;
   localparam int Tmo = 200;

   logic       aclk;
   logic       areset_n;
   logic [2:0] dbg_state;

   renode_axi_burst_manager_if #(.AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)) bus ();

   renode_axi_burst_manager #(.AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)) dut (
      .aclk      (aclk),
      .areset_n  (areset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic rd_toggle = 1'b0;

   // expected queues: {id, addr, len, size, burst}, {last, strb, data}, {last, data}, error
   logic [52:0] exp_ar_q[$];
   logic [52:0] exp_aw_q[$];
   logic [36:0] exp_w_q[$];
   logic [32:0] exp_rd_q[$];
   logic [0:0]  exp_rsp_q[$];

   // ---------------- clock / reset ----------------
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion before it");
      $fatal(1, "watchdog");
   end

   // read-beat consumer: toggles rd_ready while rd_toggle is set
   initial begin
      bus.rd_ready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         if (rd_toggle) bus.rd_ready = ~bus.rd_ready;
         else           bus.rd_ready = 1'b1;
      end
   end

   // ---------------- helpers / driver tasks ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // Wait (bounded) at negedges for a condition selected by sel.
   task automatic wait_sig(input int sel, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < Tmo && !hit; i++) begin
         @(negedge aclk);
         case (sel)
            0: hit = bus.cmd_ready;
            1: hit = bus.arvalid && bus.arready;
            2: hit = bus.awvalid && bus.awready;
            3: hit = bus.wvalid && bus.wready;
            4: hit = bus.rvalid && bus.rready;
            5: hit = bus.bvalid && bus.bready;
            6: hit = bus.rsp_valid;
            7: hit = bus.rsp_valid && bus.rsp_ready;
            default: hit = bus.awvalid;
         endcase
      end
      if (!hit) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: timeout, required event within %0d cycles", name, Tmo);
      end
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [7:0] len, input logic [7:0] id);
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_size  = size;
      bus.cmd_len   = len;
      bus.cmd_id    = id;
      bus.cmd_valid = 1'b1;
      wait_sig(0, "cmd_hs");
      step();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic finish_rsp(input int stall);
      wait_sig(6, "rsp_valid");
      for (int i = 0; i < stall; i++) begin
         step();
         @(negedge aclk);
         check("rsp_hold", bus.rsp_valid, 1'b1);
      end
      step();
      bus.rsp_ready = 1'b1;
      wait_sig(7, "rsp_hs");
      step();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                          input logic [7:0] id, input int ar_stall, input int err_beat,
                          input logic [7:0] rid_v, input logic exp_err);
      exp_ar_q.push_back({id, addr, len, size, 2'b01});
      for (int i = 0; i <= int'(len); i++)
         exp_rd_q.push_back({(i == int'(len)), 32'hD000_0000 + 32'(i)});
      exp_rsp_q.push_back(exp_err);
      send_cmd(1'b0, addr, size, len, id);
      @(negedge aclk);
      check("ar_latency_c1", bus.arvalid, 1'b0);
      @(negedge aclk);
      check("ar_latency_c2", bus.arvalid, 1'b1);
      for (int i = 0; i < ar_stall; i++) step();
      step();
      bus.arready = 1'b1;
      wait_sig(1, "ar_hs");
      step();
      bus.arready = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         bus.rvalid = 1'b1;
         bus.rid    = rid_v;
         bus.rdata  = 32'hD000_0000 + 32'(i);
         bus.rlast  = (i == int'(len));
         bus.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         wait_sig(4, "r_hs");
         step();
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
      finish_rsp(0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                           input logic [7:0] id, input logic [31:0] exp_strbs,
                           input logic [7:0] bid_v, input logic exp_err, input int rsp_stall);
      exp_aw_q.push_back({id, addr, len, size, 2'b01});
      for (int i = 0; i <= int'(len); i++)
         exp_w_q.push_back({(i == int'(len)), exp_strbs[i*4 +: 4], 32'hA000_0000 + 32'(i)});
      exp_rsp_q.push_back(exp_err);
      send_cmd(1'b1, addr, size, len, id);
      @(negedge aclk);
      check("aw_latency_c1", bus.awvalid, 1'b0);
      @(negedge aclk);
      check("aw_latency_c2", bus.awvalid, 1'b1);
      step();
      bus.awready = 1'b1;
      wait_sig(2, "aw_hs");
      step();
      bus.awready = 1'b0;
      bus.wready  = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 32'hA000_0000 + 32'(i);
         wait_sig(3, "w_hs");
         step();
      end
      bus.wr_valid = 1'b0;
      bus.bvalid   = 1'b1;
      bus.bid      = bid_v;
      bus.bresp    = 2'b00;
      wait_sig(5, "b_hs");
      step();
      bus.bvalid = 1'b0;
      bus.wready = 1'b0;
      finish_rsp(rsp_stall);
   endtask

   task automatic do_illegal(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [7:0] len, input logic [7:0] id);
      exp_rsp_q.push_back(1'b1);
      send_cmd(wr, addr, size, len, id);
      @(negedge aclk);
      check("illegal_c1_ar_aw_rsp", {bus.arvalid, bus.awvalid, bus.rsp_valid}, 3'b000);
      @(negedge aclk);
      check("illegal_c2_ar_aw_rsp", {bus.arvalid, bus.awvalid, bus.rsp_valid}, 3'b001);
      finish_rsp(0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic [52:0] e_a;
      logic [36:0] e_w;
      logic [32:0] e_r;
      logic [0:0]  e_s;
      logic        ar_hold, aw_hold;
      logic [52:0] ar_prev, aw_prev;
      ar_hold = 1'b0;
      aw_hold = 1'b0;
      ar_prev = '0;
      aw_prev = '0;
      forever begin
         @(negedge aclk);
         if (!areset_n) begin
            ar_hold = 1'b0;
            aw_hold = 1'b0;
         end else begin
            if (ar_hold)
               check("ar_stable", {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst},
                     {1'b1, ar_prev});
            if (aw_hold)
               check("aw_stable", {bus.awvalid, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
                     {1'b1, aw_prev});
            ar_hold = bus.arvalid && !bus.arready;
            aw_hold = bus.awvalid && !bus.awready;
            ar_prev = {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst};
            aw_prev = {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst};

            if (bus.arvalid && bus.arready) begin
               if (exp_ar_q.size() == 0) check("ar_unexpected", {bus.araddr}, 32'd0 - 32'd1);
               else begin
                  e_a = exp_ar_q.pop_front();
                  check("ar_payload", {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst}, e_a);
               end
            end
            if (bus.awvalid && bus.awready) begin
               if (exp_aw_q.size() == 0) check("aw_unexpected", {bus.awaddr}, 32'd0 - 32'd1);
               else begin
                  e_a = exp_aw_q.pop_front();
                  check("aw_payload", {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst}, e_a);
               end
            end
            if (bus.wvalid && bus.wready) begin
               if (exp_w_q.size() == 0) check("w_unexpected", {1'b1, bus.wdata}, 33'd0);
               else begin
                  e_w = exp_w_q.pop_front();
                  check("w_last_strb_data", {bus.wlast, bus.wstrb, bus.wdata}, e_w);
               end
            end
            if (bus.rd_valid && bus.rd_ready) begin
               if (exp_rd_q.size() == 0) check("rd_unexpected", {1'b1, bus.rd_data}, 33'd0);
               else begin
                  e_r = exp_rd_q.pop_front();
                  check("rd_last_data", {bus.rd_last, bus.rd_data}, e_r);
               end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (exp_rsp_q.size() == 0) check("rsp_unexpected", 2'b11, 2'b00);
               else begin
                  e_s = exp_rsp_q.pop_front();
                  check("rsp_error", bus.rsp_error, e_s);
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      areset_n      = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_size  = '0;
      bus.cmd_len   = '0;
      bus.cmd_id    = '0;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = '0;
      bus.rsp_ready = 1'b0;
      bus.awready   = 1'b0;
      bus.wready    = 1'b1;
      bus.bid       = '0;
      bus.bresp     = '0;
      bus.bvalid    = 1'b0;
      bus.arready   = 1'b0;
      bus.rid       = '0;
      bus.rdata     = '0;
      bus.rresp     = '0;
      bus.rlast     = 1'b0;
      bus.rvalid    = 1'b1;

      // reset state, with beat-stream inputs active to show gating
      #12;
      check("reset_cmd_ready", bus.cmd_ready, 1'b0);
      check("reset_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
                             bus.rd_valid, bus.rsp_valid, bus.rsp_error}, 8'h00);
      check("reset_state", dbg_state, 3'd0);
      check("reset_latched", {bus.araddr, bus.arlen, bus.arid}, 48'd0);
      bus.wr_valid = 1'b0;
      bus.wready   = 1'b0;
      bus.rvalid   = 1'b0;
      #10 areset_n = 1'b1;
      step();
      check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);

      // read 0x100 size 2 len 3 id 5, arready stalled 5 cycles, rd_ready toggling
      rd_toggle = 1'b1;
      do_read(32'h100, 3'd2, 8'd3, 8'h05, 5, -1, 8'h05, 1'b0);
      rd_toggle = 1'b0;

      // write 0x102 size 1 len 1: strobes 1100 then 0011, rsp_ready low 3 cycles
      do_write(32'h102, 3'd1, 8'd1, 8'h21, 32'h0000_003C, 8'h21, 1'b0, 3);

      // illegal: 4 KiB crossing, misaligned, beat wider than the bus
      do_illegal(1'b1, 32'hFFC, 3'd2, 8'd1, 8'h31);
      do_illegal(1'b0, 32'h101, 3'd2, 8'd0, 8'h32);
      do_illegal(1'b0, 32'h100, 3'd3, 8'd0, 8'h33);

      // burst ending exactly on the 4 KiB boundary is legal
      do_read(32'hFF8, 3'd2, 8'd1, 8'h44, 0, -1, 8'h44, 1'b0);

      // SLVERR on beat 2 of 4: all beats forwarded, error reported
      do_read(32'h400, 3'd2, 8'd3, 8'h09, 0, 1, 8'h09, 1'b1);

      // bid mismatch
      do_write(32'h300, 3'd2, 8'd0, 8'h07, 32'h0000_000F, 8'h08, 1'b1, 0);

      // reset during W after 2 of 4 beats
      exp_aw_q.push_back({8'h0B, 32'h200, 8'd3, 3'd2, 2'b01});
      exp_w_q.push_back({1'b0, 4'hF, 32'hA000_0000});
      exp_w_q.push_back({1'b0, 4'hF, 32'hA000_0001});
      send_cmd(1'b1, 32'h200, 3'd2, 8'd3, 8'h0B);
      wait_sig(8, "aw_valid");
      step();
      bus.awready = 1'b1;
      wait_sig(2, "aw_hs");
      step();
      bus.awready = 1'b0;
      bus.wready  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 32'hA000_0000 + 32'(i);
         wait_sig(3, "w_hs");
         step();
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'hA000_0002;
      #1 check("w_beat3_before_reset", bus.wvalid, 1'b1);
      #1 areset_n = 1'b0;
      #1;
      check("abort_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
                             bus.rd_valid, bus.rsp_valid, bus.rsp_error, bus.cmd_ready}, 9'h000);
      check("abort_state", dbg_state, 3'd0);
      bus.wr_valid = 1'b0;
      bus.wready   = 1'b0;
      repeat (3) @(posedge aclk);
      #2 areset_n = 1'b1;
      step();
      check("after_abort_cmd_ready", bus.cmd_ready, 1'b1);

      // a new command completes normally after the abort
      do_read(32'h80, 3'd2, 8'd1, 8'h03, 0, -1, 8'h03, 1'b0);

      repeat (3) step();
      check("ar_queue_empty", exp_ar_q.size(), 0);
      check("aw_queue_empty", exp_aw_q.size(), 0);
      check("w_queue_empty", exp_w_q.size(), 0);
      check("rd_queue_empty", exp_rd_q.size(), 0);
      check("rsp_queue_empty", exp_rsp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/renode_axi_burst_manager.md
RENODE_AXI_BURST_MANAGER -- requirements
Module: renode_axi_burst_manager

Interface
REQ-001 SHALL have parameter AddressWidth, default 32: AXI and command address width.
REQ-002 SHALL have parameter DataWidth, default 32: AXI data width, power of two, 8..1024.
REQ-003 SHALL have parameter TransactionIdWidth, default 8: AXI ID width; StrobeWidth = DataWidth/8 is derived.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are named aclk and areset_n.
REQ-005 aclk  input  1  clock; every flop samples on its rising edge.
REQ-006 areset_n  input  1  asynchronous active-low reset.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_write, cmd_addr, cmd_size, cmd_len, cmd_id  input  1/AddressWidth/3/8/TransactionIdWidth  command: direction, start address, log2 bytes per beat, beats-1, ID.
REQ-009 wr_valid/wr_ready/wr_data  in/out/in  1/1/DataWidth  write-beat stream; data is already lane-positioned.
REQ-010 rd_valid/rd_ready/rd_data/rd_last  out/in/out/out  1/1/DataWidth/1  read-beat stream.
REQ-011 rsp_valid/rsp_ready/rsp_error  out/in/out  1/1/1  completion of a command.
REQ-012 AXI4 manager ports: AW, W, B, AR and R channels with the standard signal names, all in standard directions and widths; *burst is fixed to 2'b01 (INCR).

Function
REQ-013 SHALL implement the FSM states IDLE, CHECK, AR, R, AW, W, B and RSP, with at most one outstanding command.
REQ-014 IDLE: cmd_ready=1; a cmd handshake latches all cmd fields and moves the FSM to CHECK; cmd_ready=0 in every other state.
REQ-015 CHECK (1 cycle): the command is illegal if 2**size > StrobeWidth, or if addr is not aligned to 2**size, or if addr + (len+1)*2**size crosses a 4 KiB boundary.
REQ-016 An illegal command goes to RSP with rsp_error=1 and SHALL issue no AXI activity.
REQ-017 A legal write goes to AW; a legal read goes to AR.
REQ-018 AR: arvalid=1 with the latched id/addr/len/size; arvalid and payload stay stable until arready; the handshake moves the FSM to R.
REQ-019 R: rready=rd_ready, and rd_valid=rvalid, rd_data=rdata and rd_last=rlast are combinational pass-through.
REQ-020 In R, each R handshake with rresp!=OKAY, rid!=latched id, or an early or missing rlast relative to the beat counter sets a sticky error.
REQ-021 The R handshake with rlast=1 moves the FSM to RSP.
REQ-022 AW: awvalid=1 with stable payload until awready; the handshake moves the FSM to W.
REQ-023 W: wvalid=wr_valid, wr_ready=wready, wdata=wr_data.
REQ-024 In W, wstrb = ((1<<2**size)-1) << (beat_addr mod StrobeWidth).
REQ-025 In W, wlast=1 exactly when the beat counter equals len; after each beat handshake beat_addr increments by 2**size.
REQ-026 The wlast beat handshake moves the FSM to B.
REQ-027 B: bready=1; the handshake sets the error if bresp!=OKAY or bid!=latched id, then moves the FSM to RSP.
REQ-028 RSP: rsp_valid=1 and rsp_error=sticky error, both held until rsp_ready; the handshake clears the error and returns the FSM to IDLE.
REQ-029 The beat counter is 8 bits, is cleared on entry to R and W, and does not wrap for len=255.
REQ-030 Latency: AXI valid asserts 2 cycles after the cmd handshake (CHECK, then AR/AW); rsp_valid asserts the cycle after the final R or B handshake.
REQ-031 All AXI valids and readies other than the pass-throughs SHALL be registered, and no valid SHALL depend combinationally on the same-channel ready.

Reset
REQ-032 While areset_n=0: FSM=IDLE; awvalid, wvalid, arvalid, bready, rready, rd_valid, rsp_valid and rsp_error are all 0; the error, counters and latched fields are 0; cmd_ready=0 while in reset.
REQ-033 An assertion of areset_n mid-burst SHALL abort immediately with no rsp generated; after deassertion, cmd_ready=1 on the first clock edge.

Verification
REQ-034 Read: addr 0x100, size 2, len 3, id 5, subordinate returns OKAY with rid 5 -> araddr 0x100, arlen 3; 4 rd beats; rd_last on beat 4; rsp_error=0.
REQ-035 Write: addr 0x102, size 1, len 1, DataWidth 32 -> wstrb 4'b1100 then 4'b0011; wlast on beat 2; bresp OKAY gives rsp_error=0.
REQ-036 Illegal: addr 0xFFC, size 2, len 1 (4 KiB crossing), or addr 0x101 with size 2 -> no arvalid/awvalid; rsp_valid 2 cycles after the cmd handshake with rsp_error=1.
REQ-037 Errors: rresp SLVERR on beat 2 of 4 -> all 4 beats forwarded, then rsp_error=1; bid mismatch -> rsp_error=1.
REQ-038 Backpressure: arready held low 5 cycles -> arvalid and payload stable; rd_ready toggling -> no beat lost or duplicated; rsp_ready low 3 cycles -> rsp held.
REQ-039 Reset in W after 2 of 4 beats -> all valids drop asynchronously; a new cmd is accepted after reset and completes normally.
